wb_stage_param: RTL and testbench

Parametrised write-back stage, successor to the fixed 32-bit WB stage. It sits between the MEM stage and the register file / debug trace port. It adds:
- configurable data, PC and register-address widths;
- a back-pressure input from the register-file port;
- exception retirement, with a one-cycle flush pulse and a kill window for in-flight MEM data.

---
 rtl/wb_stage_param.sv | 122 ++++++++++++
 tb/tb_wb_stage_param.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_param.sv
// Parametrised write-back stage: register-file write, forwarding, exception flush with a one-cycle kill window.
// Optional retirement counter port retire_cnt is enabled by defining WB_PERF_CNT_EN.
module wb_stage_param #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 32,
  parameter int REG_AW  = 5,
  parameter int ECODE_W = 6,
  localparam int BUS_W  = 1 + ECODE_W + 1 + REG_AW + DATA_W + PC_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_to_wb_valid,
  input  logic [BUS_W-1:0]   mem_to_wb_bus,
  input  logic               rf_stall,
  output logic               wb_allow,
  output logic               rf_we,
  output logic [REG_AW-1:0]  rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic [REG_AW-1:0]  wb_dest_bus,
  output logic [DATA_W-1:0]  wb_value_bus,
  output logic               wb_flush,
  output logic [PC_W-1:0]    wb_ex_pc,
  output logic [ECODE_W-1:0] wb_ex_ecode,
  output logic [PC_W-1:0]    debug_wb_pc,
  output logic [3:0]         debug_wb_rf_we,
  output logic [REG_AW-1:0]  debug_wb_rf_wnum,
  output logic [DATA_W-1:0]  debug_wb_rf_wdata
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]        retire_cnt
`endif
);

  typedef enum logic {RUN, KILL} state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic               r_wbValid;
  logic [BUS_W-1:0]   r_bus;

  logic               w_ex;
  logic [ECODE_W-1:0] w_ecode;
  logic               w_grWe;
  logic [REG_AW-1:0]  w_dest;
  logic [DATA_W-1:0]  w_result;
  logic [PC_W-1:0]    w_pc;
  logic               w_wbGo;
  logic               w_run;
  logic               w_accept;

  assign {w_ex, w_ecode, w_grWe, w_dest, w_result, w_pc} = r_bus;

  assign w_wbGo   = ~rf_stall;
  assign w_run    = (r_state == RUN);
  assign wb_allow = ~r_wbValid | w_wbGo;
  assign wb_flush = r_wbValid & w_ex & w_wbGo;
  // Nothing is latched in the flush cycle or the kill cycle after it.
  assign w_accept = mem_to_wb_valid & wb_allow & w_run & ~wb_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wbValid <= 1'b0;
      r_bus     <= '0;
    end else begin
      if (wb_allow) begin
        r_wbValid <= mem_to_wb_valid & w_run & ~wb_flush;
      end
      if (w_accept) begin
        r_bus <= mem_to_wb_bus;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      RUN:     if (wb_flush) w_stateNext = KILL;
      KILL:    w_stateNext = RUN;
      default: w_stateNext = RUN;
    endcase
  end

  // Forwarding ignores rf_stall so a held result stays visible to the decode stage.
  assign wb_dest_bus  = (r_wbValid & w_grWe & ~w_ex) ? w_dest : '0;
  assign wb_value_bus = w_result;

  assign rf_we    = r_wbValid & w_grWe & ~w_ex & (w_dest != '0) & w_wbGo;
  assign rf_waddr = w_dest;
  assign rf_wdata = w_result;

  assign wb_ex_pc    = w_pc;
  assign wb_ex_ecode = w_ecode;

  assign debug_wb_pc       = w_pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = w_dest;
  assign debug_wb_rf_wdata = w_result;

`ifdef WB_PERF_CNT_EN
  logic [31:0] r_retireCnt;

  // Excepting instructions retire too, so they are counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retireCnt <= '0;
    end else if (r_wbValid & w_wbGo) begin
      r_retireCnt <= r_retireCnt + 32'd1;
    end
  end

  assign retire_cnt = r_retireCnt;
`endif

endmodule

// File: tb/tb_wb_stage_param.sv
// Scoreboard bench for wb_stage_param: a transaction-level model predicts retirement events and
// per-cycle handshake values; a negedge monitor pops and compares against the DUT.
module tb_wb_stage_param;

  localparam int DATA_W  = 32;
  localparam int PC_W    = 32;
  localparam int REG_AW  = 5;
  localparam int ECODE_W = 6;
  localparam int BUS_W   = 1 + ECODE_W + 1 + REG_AW + DATA_W + PC_W;

  typedef struct packed {
    logic               ex;
    logic [ECODE_W-1:0] ecode;
    logic               grWe;
    logic [REG_AW-1:0]  dest;
    logic [DATA_W-1:0]  result;
    logic [PC_W-1:0]    pc;
  } instr_t;

  typedef struct {
    bit                 isFlush;
    logic [REG_AW-1:0]  dest;
    logic [DATA_W-1:0]  data;
    logic [PC_W-1:0]    pc;
    logic [ECODE_W-1:0] ecode;
  } evt_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               mem_to_wb_valid = 1'b0;
  logic [BUS_W-1:0]   mem_to_wb_bus = '0;
  logic               rf_stall = 1'b0;
  logic               wb_allow;
  logic               rf_we;
  logic [REG_AW-1:0]  rf_waddr;
  logic [DATA_W-1:0]  rf_wdata;
  logic [REG_AW-1:0]  wb_dest_bus;
  logic [DATA_W-1:0]  wb_value_bus;
  logic               wb_flush;
  logic [PC_W-1:0]    wb_ex_pc;
  logic [ECODE_W-1:0] wb_ex_ecode;
  logic [PC_W-1:0]    debug_wb_pc;
  logic [3:0]         debug_wb_rf_we;
  logic [REG_AW-1:0]  debug_wb_rf_wnum;
  logic [DATA_W-1:0]  debug_wb_rf_wdata;
`ifdef WB_PERF_CNT_EN
  logic [31:0]        retire_cnt;
`endif

  wb_stage_param #(
    .DATA_W(DATA_W), .PC_W(PC_W), .REG_AW(REG_AW), .ECODE_W(ECODE_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_to_wb_valid(mem_to_wb_valid),
    .mem_to_wb_bus(mem_to_wb_bus),
    .rf_stall(rf_stall),
    .wb_allow(wb_allow),
    .rf_we(rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .wb_dest_bus(wb_dest_bus),
    .wb_value_bus(wb_value_bus),
    .wb_flush(wb_flush),
    .wb_ex_pc(wb_ex_pc),
    .wb_ex_ecode(wb_ex_ecode),
    .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
`ifdef WB_PERF_CNT_EN
    ,
    .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;
  bit monOn      = 1'b0;
  evt_t expQ[$];

  // Model: the WB slot holds at most one instruction; a flush opens a one-cycle kill window.
  bit          mSlotValid = 1'b0;
  instr_t      mSlot      = '0;
  bit          mKill      = 1'b0;
  logic [31:0] mCnt       = '0;
  bit          curAllow   = 1'b1;
  bit          curFlush   = 1'b0;
  bit          curWe      = 1'b0;
  logic [REG_AW-1:0] curDest = '0;
  logic [31:0] curCnt     = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic instr_t makeIns(bit ex, logic [ECODE_W-1:0] ecode, bit grWe,
                                     logic [REG_AW-1:0] dest, logic [DATA_W-1:0] result,
                                     logic [PC_W-1:0] pc);
    instr_t i;
    i.ex = ex; i.ecode = ecode; i.grWe = grWe; i.dest = dest; i.result = result; i.pc = pc;
    return i;
  endfunction

  function automatic void modelReset();
    mSlotValid = 1'b0;
    mSlot      = '0;
    mKill      = 1'b0;
    mCnt       = '0;
    expQ.delete();
  endfunction

  function automatic void modelStep(bit valid, instr_t ins, bit stall);
    instr_t s = mSlot;
    bit retire;
    evt_t e;
    curAllow = !mSlotValid || !stall;
    retire   = mSlotValid && !stall;
    curFlush = retire && s.ex;
    curWe    = retire && !s.ex && s.grWe && (s.dest != '0);
    curDest  = (mSlotValid && s.grWe && !s.ex) ? s.dest : '0;
    curCnt   = mCnt;
    if (retire) begin
      mCnt = mCnt + 32'd1;
      if (s.ex) begin
        e = '{1'b1, '0, '0, s.pc, s.ecode};
        expQ.push_back(e);
      end else if (curWe) begin
        e = '{1'b0, s.dest, s.result, s.pc, '0};
        expQ.push_back(e);
      end
    end
    if (curAllow) begin
      mSlotValid = valid && !mKill && !curFlush;
      if (mSlotValid) mSlot = ins;
    end
    mKill = curFlush;
  endfunction

  task automatic applyStimulus(input bit valid, input instr_t ins, input bit stall);
    @(posedge clk);
    #1;
    mem_to_wb_valid = valid;
    mem_to_wb_bus   = ins;
    rf_stall        = stall;
    modelStep(valid, ins, stall);
  endtask

  task automatic releaseReset();
    repeat (2) @(posedge clk);
    #1;
    reset           = 1'b0;
    mem_to_wb_valid = 1'b0;
    mem_to_wb_bus   = '0;
    rf_stall        = 1'b0;
    modelReset();
    modelStep(1'b0, '0, 1'b0);
    monOn = 1'b1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " rf_we"}, rf_we, 0);
    checkOutput({tag, " wb_flush"}, wb_flush, 0);
    checkOutput({tag, " wb_allow"}, wb_allow, 1);
    checkOutput({tag, " wb_dest_bus"}, wb_dest_bus, 0);
    checkOutput({tag, " debug_wb_pc"}, debug_wb_pc, 0);
    checkOutput({tag, " wb_ex_pc"}, wb_ex_pc, 0);
`ifdef WB_PERF_CNT_EN
    checkOutput({tag, " retire_cnt"}, retire_cnt, 0);
`endif
  endtask

  always @(negedge clk) begin
    if (monOn) begin
      evt_t e;
      checkOutput("wb_allow", wb_allow, curAllow);
      checkOutput("wb_flush", wb_flush, curFlush);
      checkOutput("rf_we", rf_we, curWe);
      checkOutput("debug_wb_rf_we", debug_wb_rf_we, {4{curWe}});
      checkOutput("wb_dest_bus", wb_dest_bus, curDest);
`ifdef WB_PERF_CNT_EN
      checkOutput("retire_cnt", retire_cnt, curCnt);
`endif
      if (rf_we || wb_flush) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected retire event", 1, 0);
        end else begin
          e = expQ.pop_front();
          if (e.isFlush) begin
            checkOutput("event kind flush", wb_flush, 1);
            checkOutput("wb_ex_pc", wb_ex_pc, e.pc);
            checkOutput("wb_ex_ecode", wb_ex_ecode, e.ecode);
          end else begin
            checkOutput("event kind write", rf_we, 1);
            checkOutput("rf_waddr", rf_waddr, e.dest);
            checkOutput("rf_wdata", rf_wdata, e.data);
            checkOutput("wb_value_bus", wb_value_bus, e.data);
            checkOutput("debug_wb_pc", debug_wb_pc, e.pc);
            checkOutput("debug_wb_rf_wnum", debug_wb_rf_wnum, e.dest);
            checkOutput("debug_wb_rf_wdata", debug_wb_rf_wdata, e.data);
          end
        end
      end
    end
  end

  initial begin
    instr_t ins;
    $display("[TB] start");
    @(posedge clk);
    #1;
    checkResetOutputs("reset");
    releaseReset();

    // Normal write.
    applyStimulus(1, makeIns(0, 0, 1, 5, 32'h1234_5678, 32'h1C00_0000), 0);
    applyStimulus(0, '0, 0);
    #1;
    checkOutput("T1 rf_we", rf_we, 1);
    checkOutput("T1 rf_waddr", rf_waddr, 5);
    checkOutput("T1 rf_wdata", rf_wdata, 32'h1234_5678);
    checkOutput("T1 debug_wb_rf_we", debug_wb_rf_we, 4'hF);
    checkOutput("T1 wb_dest_bus", wb_dest_bus, 5);

    // Stall holds dest 7; data offered during the stall is not taken.
    applyStimulus(1, makeIns(0, 0, 1, 7, 32'hAAAA_0007, 32'h1C00_0004), 0);
    applyStimulus(1, makeIns(0, 0, 1, 9, 32'hBBBB_0009, 32'h1C00_0008), 1);
    #1;
    checkOutput("T2 wb_allow", wb_allow, 0);
    checkOutput("T2 rf_we", rf_we, 0);
    checkOutput("T2 wb_dest_bus", wb_dest_bus, 7);
    applyStimulus(1, makeIns(0, 0, 1, 9, 32'hBBBB_0009, 32'h1C00_0008), 1);
    applyStimulus(0, '0, 0);
    applyStimulus(0, '0, 0);

    // Exception with valid MEM data in the flush cycle and in the kill cycle.
    applyStimulus(1, makeIns(1, 6'h0B, 1, 3, 32'hDEAD_0003, 32'h1C00_0010), 0);
    applyStimulus(1, makeIns(0, 0, 1, 3, 32'hCCCC_0003, 32'h1C00_0014), 0);
    #1;
    checkOutput("T3 wb_flush", wb_flush, 1);
    checkOutput("T3 wb_ex_pc", wb_ex_pc, 32'h1C00_0010);
    checkOutput("T3 wb_ex_ecode", wb_ex_ecode, 6'h0B);
    checkOutput("T3 rf_we", rf_we, 0);
    applyStimulus(1, makeIns(0, 0, 1, 4, 32'hCCCC_0004, 32'h1C00_0018), 0);
    #1;
    checkOutput("T3 kill wb_flush", wb_flush, 0);
    applyStimulus(0, '0, 0);
    #1;
    checkOutput("T3 dropped rf_we", rf_we, 0);

    // Exception held by a 3-cycle stall.
    applyStimulus(1, makeIns(1, 6'h15, 0, 0, 32'h0, 32'h1C00_0020), 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, '0, 1);
      #1;
      checkOutput("T4 stalled wb_flush", wb_flush, 0);
    end
    applyStimulus(0, '0, 0);
    #1;
    checkOutput("T4 released wb_flush", wb_flush, 1);
    applyStimulus(0, '0, 0);

    // Write to register zero is suppressed.
    applyStimulus(1, makeIns(0, 0, 1, 0, 32'h5555_5555, 32'h1C00_0030), 0);
    applyStimulus(0, '0, 0);
    #1;
    checkOutput("T5 rf_we", rf_we, 0);
    checkOutput("T5 wb_dest_bus", wb_dest_bus, 0);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      ins = makeIns(($urandom % 8) == 0, ECODE_W'($urandom), ($urandom % 4) != 0,
                    REG_AW'($urandom), $urandom, $urandom);
      applyStimulus(($urandom % 4) != 0, ins, ($urandom % 4) == 0);
    end
    applyStimulus(0, '0, 0);
    applyStimulus(0, '0, 0);
    #1;
    checkOutput("queue drained", expQ.size(), 0);

    // Reset between edges while a write is stalled.
    applyStimulus(1, makeIns(0, 0, 1, 12, 32'h0000_0C0C, 32'h1C00_0040), 0);
    applyStimulus(0, '0, 1);
    @(negedge clk);
    #1;
    monOn = 1'b0;
    reset = 1'b1;
    #1;
    checkResetOutputs("reset mid-stall");
    releaseReset();

    // Reset between edges in the kill cycle.
    applyStimulus(1, makeIns(1, 6'h02, 0, 0, 32'h0, 32'h1C00_0050), 0);
    applyStimulus(1, makeIns(0, 0, 1, 6, 32'h0000_0006, 32'h1C00_0054), 0);
    applyStimulus(1, makeIns(0, 0, 1, 8, 32'h0000_0008, 32'h1C00_0058), 0);
    @(negedge clk);
    #1;
    monOn = 1'b0;
    reset = 1'b1;
    #1;
    checkResetOutputs("reset mid-kill");
    releaseReset();

    // Three retirements, the last one excepting.
    applyStimulus(1, makeIns(0, 0, 1, 10, 32'h0000_000A, 32'h1C00_0060), 0);
    applyStimulus(1, makeIns(0, 0, 0, 11, 32'h0000_000B, 32'h1C00_0064), 0);
    applyStimulus(1, makeIns(1, 6'h01, 0, 0, 32'h0, 32'h1C00_0068), 0);
    applyStimulus(0, '0, 0);
    applyStimulus(0, '0, 0);
    #1;
`ifdef WB_PERF_CNT_EN
    checkOutput("retire_cnt after 3", retire_cnt, 32'd3);
`endif
    checkOutput("final queue drained", expQ.size(), 0);
    monOn = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
